// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline-stage register.
// Carries an opaque DATA_W-bit payload between two valid/ready interfaces
// and replaces the per-stage latches of the pipeline with one block.
//
// Handshake: a beat moves on a side only in a cycle where both valid and
// ready are high on that side (push = in_valid & in_ready,
// pop = out_valid & out_ready). Both sides are evaluated in the same cycle.
// valid must not depend on ready. in_ready and out_valid are forced low while
// flush or freeze is high, so no beat moves on either side in those cycles.
//
// SKID=1: two entries (main M, skid S). in_ready comes from state only,
//         which breaks the combinational stall path back to upstream.
// SKID=0: one entry M. in_ready passes out_ready through when full.
//
// The FSM state is exposed directly on occupancy: EMPTY=0, ONE=1, TWO=2.
module pipe_stage_elastic #(
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   m_q;
  logic [DATA_W-1:0]   s_q;
  logic [CNT_W-1:0]    stall_q;
  logic [CNT_W-1:0]    stall_d;

  logic                hold_all;
  logic                held_valid;
  logic                base_ready;
  logic                push;
  logic                pop;

  // Handshake signals; flush and freeze mask both sides.
  always_comb begin
    hold_all   = flush | freeze;
    held_valid = (state_q != ST_EMPTY);
    if (SKID != 0) begin
      base_ready = (state_q != ST_TWO);
    end else begin
      base_ready = !held_valid || out_ready;
    end
    in_ready  = base_ready && !hold_all;
    out_valid = held_valid && !hold_all;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Saturating back-pressure counter: counts cycles where a valid entry waits on downstream.
  always_comb begin
    stall_d = stall_q;
    if (held_valid && !out_ready && !hold_all && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Occupancy FSM and entry registers; reset beats flush, flush beats freeze.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
      if (flush) begin
        state_q <= ST_EMPTY;
        m_q     <= '0;
        s_q     <= '0;
      end else if (!freeze) begin
        case (state_q)
          ST_EMPTY: begin
            if (push) begin
              state_q <= ST_ONE;
              m_q     <= in_data;
            end
          end
          ST_ONE: begin
            if (push && !pop) begin
              // Only reachable with SKID=1: with SKID=0 a push into a full
              // stage implies a pop in the same cycle.
              state_q <= ST_TWO;
              s_q     <= in_data;
            end else if (pop && !push) begin
              state_q <= ST_EMPTY;
              m_q     <= '0;
            end else if (push && pop) begin
              m_q     <= in_data;
            end
          end
          ST_TWO: begin
            if (pop) begin
              state_q <= ST_ONE;
              m_q     <= s_q;
              s_q     <= '0;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
          end
        endcase
      end
    end
  end

  assign out_data     = m_q;
  assign occupancy    = state_q;
  assign stall_cycles = stall_q;

endmodule
